// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared button indices, debounce defaults and arbiter helper
package button_debouncer_pkg;

   localparam int BTN_A  = 0;
   localparam int BTN_B  = 1;
   localparam int BTN_OP = 2;

   localparam int N_BUTTONS_DEFAULT       = 3;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

   // Isolates the lowest set bit; callers keep their vectors within 32 bits.
   function automatic logic [31:0] lowest_set(input logic [31:0] v);
      return v & (~v + 32'd1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: 2-FF synchroniser, counter debounce filter, press flag
module debounce_channel
   import button_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             at_last;

   assign at_last = (cnt_q == CNT_LAST);

   // Any agreement with the stable level throws away the run so far.
   always_comb begin
      sync1_d  = raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (at_last) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign level = stable_q;
   assign rise  = sync2_q & ~stable_q & at_last;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - debounced button levels plus one-hot registered press strobes
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int N_BUTTONS       = N_BUTTONS_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic                 input_clock,
   input  logic                 input_reset,
   input  logic [N_BUTTONS-1:0] input_buttons,
   output logic [N_BUTTONS-1:0] output_buttons_level,
   output logic [N_BUTTONS-1:0] output_buttons_pulse
);

   logic [N_BUTTONS-1:0] rise;
   logic [N_BUTTONS-1:0] pulse_d, pulse_q;

   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
         .clock(input_clock),
         .reset(input_reset),
         .raw  (input_buttons[i]),
         .level(output_buttons_level[i]),
         .rise (rise[i])
      );
   end

   // Coinciding presses: lowest index wins, the others are dropped outright.
   always_comb begin
      pulse_d = N_BUTTONS'(lowest_set(32'(rise)));
   end

   always_ff @(posedge input_clock or posedge input_reset) begin
      if (input_reset) begin
         pulse_q <= '0;
      end else begin
         pulse_q <= pulse_d;
      end
   end

   assign output_buttons_pulse = pulse_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - randomized and directed bench with a sample-history reference model
module tb_button_debouncer;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] buttons;
   logic [2:0] level;
   logic [2:0] pulse;

   int n_checks = 0;
   int n_errors = 0;

   logic [2:0] raw_log[$];
   logic [2:0] exp_level;
   logic [2:0] exp_pulse;

   button_debouncer #(
      .N_BUTTONS      (3),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .input_clock         (clk),
      .input_reset         (rst),
      .input_buttons       (buttons),
      .output_buttons_level(level),
      .output_buttons_pulse(pulse)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      raw_log.delete();
      exp_level = 3'b000;
      exp_pulse = 3'b000;
   endtask

   // Filter input at edge k is the raw level sampled two edges earlier (0 right after reset).
   function automatic logic [2:0] s2_at(input int k);
      if (k >= 2) return raw_log[k-2];
      return 3'b000;
   endfunction

   // A level flips once the last D filter samples all disagree with it.
   task automatic model_edge(input logic [2:0] b);
      int         n;
      logic [2:0] rises;
      logic [2:0] s;
      bit         all_diff;
      if (rst) return;
      n = raw_log.size();
      raw_log.push_back(b);
      rises = 3'b000;
      for (int ch = 0; ch < 3; ch++) begin
         if (n + 1 >= D) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) begin
               s = s2_at(n - j);
               if (s[ch] == exp_level[ch]) all_diff = 1'b0;
            end
            if (all_diff) begin
               if (!exp_level[ch]) rises[ch] = 1'b1;
               exp_level[ch] = ~exp_level[ch];
            end
         end
      end
      exp_pulse = 3'b000;
      for (int ch = 0; ch < 3; ch++) begin
         if (rises[ch] && exp_pulse == 3'b000) exp_pulse[ch] = 1'b1;
      end
   endtask

   // Called at a falling edge; returns at the next falling edge after checking.
   task automatic tick(input logic [2:0] b);
      buttons = b;
      @(posedge clk);
      model_edge(b);
      @(negedge clk);
      check_eq("level", 32'(level), 32'(exp_level));
      check_eq("pulse", 32'(pulse), 32'(exp_pulse));
      check_eq("pulse_onehot", 32'($countones(pulse) <= 1), 32'd1);
   endtask

   task automatic settle();
      repeat (8) tick(3'b000);
   endtask

   int pcount;
   int first;
   int bit2_seen;
   logic [2:0] bounce[16];

   initial begin
      rst     = 1'b1;
      buttons = 3'b111;
      model_reset();
      repeat (3) @(negedge clk);
      check_eq("reset_level", 32'(level), 32'd0);
      check_eq("reset_pulse", 32'(pulse), 32'd0);

      rst = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick(3'b111);
         if (i == 6) begin
            check_eq("post_reset_pulse", 32'(pulse), 32'b001);
            check_eq("post_reset_level", 32'(level), 32'b111);
         end else begin
            check_eq("post_reset_nopulse", 32'(pulse), 32'd0);
         end
      end
      settle();

      pcount = 0; first = -1;
      for (int i = 0; i < 20; i++) begin
         tick(3'b010);
         if (pulse != 3'b000) begin pcount++; if (first < 0) first = i; end
      end
      check_eq("clean_count", 32'(pcount), 32'd1);
      check_eq("clean_latency", 32'(first), 32'd5);
      check_eq("clean_level", 32'(level), 32'b010);
      pcount = 0;
      for (int i = 0; i < 8; i++) begin
         tick(3'b000);
         if (pulse != 3'b000) pcount++;
      end
      check_eq("release_nopulse", 32'(pcount), 32'd0);
      check_eq("release_level", 32'(level), 32'd0);

      bounce = '{3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001,
                 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
                 3'b001, 3'b001, 3'b001, 3'b001};
      pcount = 0; first = -1;
      for (int i = 0; i < 16; i++) begin
         tick(bounce[i]);
         if (pulse != 3'b000) begin pcount++; if (first < 0) first = i; end
      end
      check_eq("bounce_count", 32'(pcount), 32'd1);
      check_eq("bounce_latency", 32'(first), 32'd10);
      settle();

      pcount = 0; bit2_seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick(3'b110);
         if (pulse == 3'b010) pcount++;
         if (pulse[2]) bit2_seen++;
      end
      check_eq("simul_count", 32'(pcount), 32'd1);
      check_eq("simul_bit2", 32'(bit2_seen), 32'd0);
      check_eq("simul_level", 32'(level), 32'b110);
      settle();

      repeat (8) tick(3'b001);
      repeat (3) tick(3'b100);
      check_eq("premid_level", 32'(level), 32'b001);
      #2 rst = 1'b1;
      #1;
      check_eq("midreset_level", 32'(level), 32'd0);
      check_eq("midreset_pulse", 32'(pulse), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      first = -1;
      for (int i = 0; i < 8; i++) begin
         tick(3'b100);
         if (pulse != 3'b000 && first < 0) begin
            first = i;
            check_eq("midreset_pulse_val", 32'(pulse), 32'b100);
         end
      end
      check_eq("midreset_latency", 32'(first), 32'd5);
      settle();

      pcount = 0;
      for (int i = 0; i < 100; i++) begin
         tick(3'b001);
         if (pulse != 3'b000) pcount++;
      end
      check_eq("hold_count", 32'(pcount), 32'd1);
      repeat (10) tick(3'b000);
      pcount = 0;
      for (int i = 0; i < 10; i++) begin
         tick(3'b001);
         if (pulse != 3'b000) pcount++;
      end
      check_eq("repress_count", 32'(pcount), 32'd1);

      for (int seg = 0; seg < 400; seg++) begin
         logic [2:0] v;
         int         len;
         v   = 3'($urandom);
         len = $urandom_range(1, 9);
         if ($urandom_range(0, 39) == 0) begin
            #3 rst = 1'b1;
            #1;
            check_eq("rand_reset_level", 32'(level), 32'd0);
            check_eq("rand_reset_pulse", 32'(pulse), 32'd0);
            model_reset();
            @(negedge clk);
            rst = 1'b0;
         end
         for (int k = 0; k < len; k++) tick(v);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
